coffee_brew_sequencer: RTL
==========================

Name: coffee_brew_sequencer

Overview:
- Downstream consumer of the 1 Hz output of clock_divisor.
- Turns the slow square wave into single-cycle second ticks and runs the coffee-maker brew sequence: IDLE -> HEAT -> BREW -> DONE.
- Drives the heater and pump enables, a seconds-remaining count for display/LEDs, and a done flag.
- Runs entirely in the 100 MHz system clock domain.

Parameters:
- HEAT_SECS, 30: heating phase length in ticks; legal range 1..2^CNT_W-1.
- BREW_SECS, 45: brewing phase length in ticks; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the seconds counter and of seconds_left.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- tick_in  in  1  1 Hz square wave from clock_divisor, same clock domain.
- start  in  1  begin a brew cycle; level sampled each clk.
- cancel  in  1  abort the current cycle; level sampled each clk.
- heater_en  out  1  heater on.
- pump_en  out  1  pump on.
- busy  out  1  high in HEAT or BREW.
- done  out  1  high in DONE.
- phase  out  2  state code: IDLE=0, HEAT=1, BREW=2, DONE=3.
- seconds_left  out  CNT_W  remaining ticks in the current phase.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - FSM state = IDLE, counter = 0.
  - Edge-detect registers d1 = 0, d2 = 0.
  - All outputs 0; phase = 0.
- Tick extraction:
  - d1 <= tick_in; d2 <= d1.
  - tick_p = d1 & ~d2, combinational, one clk wide per rising edge of tick_in.
  - Latency from the tick_in rise to tick_p: 1 clk.
  - If tick_in is high when rst releases, one tick_p occurs on the first cycle; it is harmless in IDLE.
- Outputs are decoded from registered state and counter only (Moore):
  - IDLE: heater_en=0, pump_en=0, busy=0, done=0, seconds_left=0.
  - HEAT: heater_en=1, pump_en=0, busy=1, seconds_left=counter.
  - BREW: heater_en=1, pump_en=1, busy=1, seconds_left=counter.
  - DONE: heater_en=0, pump_en=0, busy=0, done=1, seconds_left=0.
- Transitions, in priority order:
  1. rst: go to reset state.
  2. cancel=1 in any state: go to IDLE, counter=0. Cancel beats start and tick in the same cycle.
  3. IDLE or DONE with start=1: go to HEAT, counter=HEAT_SECS. A tick_p in that same cycle is not consumed.
  4. HEAT with tick_p:
     - counter==1: go to BREW, counter=BREW_SECS.
     - otherwise: counter-1.
  5. BREW with tick_p:
     - counter==1: go to DONE, counter=0.
     - otherwise: counter-1.
  6. Otherwise hold state and counter.
- start while busy is ignored; there is no queuing or restart.
- DONE persists indefinitely until start or cancel.
- Phase duration is N tick_p events. Wall time of the first phase is in (N-1, N] seconds because start is asynchronous to the tick phase.
- The counter never underflows; decrement happens only from values >= 2.
- Out-of-range HEAT_SECS/BREW_SECS (0 or >= 2^CNT_W) is a configuration error and must be flagged at elaboration.

Test Plan:
Common settings: HEAT_SECS=3, BREW_SECS=2; tick_in driven by the bench as a slow square wave (period 20 clk).
1. Reset: assert rst 2 clk, with tick_in held high -> all outputs 0, phase=0; one tick_p after release; FSM stays in IDLE.
2. Full cycle: pulse start 1 clk.
   - Next clk: phase=1, heater_en=1, seconds_left=3.
   - Successive tick_in rises give seconds_left 2, 1, then phase=2, pump_en=1, seconds_left=2.
   - Then seconds_left=1, then phase=3, done=1, heater_en=pump_en=0.
   - Each change occurs 2 clk after the tick_in rise (1 clk edge-detect + 1 clk register update).
3. Cancel mid-BREW with seconds_left=1, start also high that cycle -> next clk phase=0, all outputs 0; IDLE holds afterwards despite further tick_in edges.
4. start held high through HEAT and BREW -> no reload. At DONE with start still high -> one cycle of done=1, then phase=1, seconds_left=3.
5. start coincident with tick_p -> seconds_left=3, not 2. Exactly 3 further tick_p events are needed to reach BREW.
6. rst asserted during HEAT with seconds_left=2 -> next clk phase=0, outputs 0. tick_in held constant high -> no further tick_p.

Source files
------------

// File: rtl/coffee_brew_sequencer.sv
// coffee_brew_sequencer
//   Brew sequencer for the coffee maker. It takes the 1 Hz square wave from
//   clock_divisor, turns each rising edge into a single-cycle second tick, and
//   steps the brew sequence IDLE -> HEAT -> BREW -> DONE. Each timed phase is
//   a down-counter that is loaded on entry and checked for terminal count (1)
//   on every tick.
//
//   Ports
//     clk           in   system clock (100 MHz)
//     rst           in   synchronous active-high reset
//     tick_in       in   1 Hz square wave, already in the clk domain
//     start         in   begin a brew cycle (level, sampled every clk)
//     cancel        in   abort the current cycle (level, beats start/tick)
//     heater_en     out  heater on (HEAT, BREW)
//     pump_en       out  pump on (BREW)
//     busy          out  high in HEAT or BREW
//     done          out  high in DONE
//     phase         out  state code IDLE=0 HEAT=1 BREW=2 DONE=3
//     seconds_left  out  remaining ticks in the current timed phase
//
//   State | meaning
//   ------+----------------------------------------------------------
//   IDLE  | nothing running, waiting for start
//   HEAT  | heater on, counting down HEAT_SECS ticks
//   BREW  | heater and pump on, counting down BREW_SECS ticks
//   DONE  | cycle complete, held until start or cancel

module coffee_brew_sequencer #(
  parameter int HEAT_SECS = 30,
  parameter int BREW_SECS = 45,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic             cancel,
  output logic             heater_en,
  output logic             pump_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] seconds_left
);

  localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // Phase lengths must fit the counter and be non-zero; a zero length would
  // need a decrement below 1, which the terminal-count scheme never does.
  if (HEAT_SECS < 1 || longint'(HEAT_SECS) > CNT_MAX) begin : g_bad_heat
    $error("coffee_brew_sequencer: HEAT_SECS out of range 1..2^CNT_W-1");
  end
  if (BREW_SECS < 1 || longint'(BREW_SECS) > CNT_MAX) begin : g_bad_brew
    $error("coffee_brew_sequencer: BREW_SECS out of range 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] HEAT_LOAD = CNT_W'(HEAT_SECS);
  localparam logic [CNT_W-1:0] BREW_LOAD = CNT_W'(BREW_SECS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    BREW = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d1, d2;
  logic             tick_p;
  logic             cnt_tc;

  // Rising-edge detect on the slow wave; one clk wide per tick_in rise.
  assign tick_p = d1 & ~d2;
  assign cnt_tc = (cnt_q == CNT_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d1      <= 1'b0;
      d2      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d1      <= tick_in;
      d2      <= d1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // A tick landing in the start cycle is dropped so the first
          // phase always gets its full HEAT_SECS ticks.
          if (start) begin
            state_d = HEAT;
            cnt_d   = HEAT_LOAD;
          end
        end
        HEAT: begin
          if (tick_p) begin
            if (cnt_tc) begin
              state_d = BREW;
              cnt_d   = BREW_LOAD;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        BREW: begin
          if (tick_p) begin
            if (cnt_tc) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore decode from registered state and counter only.
  always_comb begin
    heater_en    = 1'b0;
    pump_en      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    seconds_left = '0;
    unique case (state_q)
      HEAT: begin
        heater_en    = 1'b1;
        busy         = 1'b1;
        seconds_left = cnt_q;
      end
      BREW: begin
        heater_en    = 1'b1;
        pump_en      = 1'b1;
        busy         = 1'b1;
        seconds_left = cnt_q;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign phase = state_q;

endmodule
